// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one FP unit among NUM_REQ APU requesters, with
// per-requester outstanding-operation limits and tag-based response routing.
module cv32e40p_apu_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NUM_REQ-1:0]                          apu_req_i,
  output logic [NUM_REQ-1:0]                          apu_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] apu_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         apu_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    apu_flags_i,
  output logic [NUM_REQ-1:0]                          apu_rvalid_o,
  output logic [NUM_REQ-1:0][31:0]                    apu_rdata_o,
  output logic [NUM_REQ-1:0][APU_NUSFLAGS_CPU-1:0]    apu_rflags_o,
  output logic                                        fpu_req_o,
  input  logic                                        fpu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]              fpu_operands_o,
  output logic [APU_WOP_CPU-1:0]                      fpu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                 fpu_flags_o,
  output logic [ID_W-1:0]                             fpu_tag_o,
  input  logic                                        fpu_rvalid_i,
  input  logic [31:0]                                 fpu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                 fpu_rflags_i,
  input  logic [ID_W-1:0]                             fpu_tag_i,
  output logic                                        busy_o,
  output logic                                        err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t                                     r_outst [NUM_REQ];
  logic [ID_W-1:0]                          r_rr_ptr;
  logic [ID_W-1:0]                          r_lock_id;
  logic                                     r_lock;
  logic                                     r_err;
  logic [NUM_REQ-1:0]                       r_rvalid;
  logic [NUM_REQ-1:0][31:0]                 r_rdata;
  logic [NUM_REQ-1:0][APU_NUSFLAGS_CPU-1:0] r_rflags;

  logic [ID_W-1:0]    w_sel;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_dec;
  logic               w_busy;
  logic               w_lock_act;
  logic               w_hs;
  logic               w_resp_bad;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_elig = '0;
    w_dec  = '0;
    w_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = apu_req_i[i] && (r_outst[i] < cnt_t'(MAX_OUTSTANDING));
      w_dec[i]  = fpu_rvalid_i && (fpu_tag_i == ID_W'(i)) && (r_outst[i] != '0);
      w_busy    = w_busy | (r_outst[i] != '0);
    end
  end

  // A stalled request stays pinned to its requester until accepted or withdrawn.
  assign w_lock_act = r_lock & apu_req_i[r_lock_id];

  // Lowest eligible index overall, overridden by the lowest eligible at/after
  // rr_ptr: equivalent to a wrap-around search starting at rr_ptr.
  always_comb begin
    w_sel = r_rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (ID_W'(i) >= r_rr_ptr)) w_sel = ID_W'(i);
    end
    if (w_lock_act) w_sel = r_lock_id;
  end

  assign fpu_req_o      = rst_ni & (w_lock_act | (|w_elig));
  assign w_hs           = fpu_req_o & fpu_gnt_i;
  assign fpu_operands_o = apu_operands_i[w_sel];
  assign fpu_op_o       = apu_op_i[w_sel];
  assign fpu_flags_o    = apu_flags_i[w_sel];
  assign fpu_tag_o      = w_sel;
  assign w_resp_bad     = fpu_rvalid_i & ~(|w_dec);

  always_comb begin
    apu_gnt_o = '0;
    if (w_hs) apu_gnt_o[w_sel] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_outst[i] <= '0;
    end else begin
      r_lock <= fpu_req_o & ~fpu_gnt_i;
      if (fpu_req_o && !fpu_gnt_i) r_lock_id <= w_sel;
      if (w_hs) r_rr_ptr <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
      if (w_resp_bad) r_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (apu_gnt_o[i] && !w_dec[i])      r_outst[i] <= r_outst[i] + cnt_t'(1);
        else if (!apu_gnt_o[i] && w_dec[i]) r_outst[i] <= r_outst[i] - cnt_t'(1);
      end
    end
  end

  // NOTE: result registers are reset too, since requesters may observe them right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rflags <= '0;
    end else begin
      r_rvalid <= w_dec;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_dec[i]) begin
          r_rdata[i]  <= fpu_rdata_i;
          r_rflags[i] <= fpu_rflags_i;
        end
      end
    end
  end

  assign apu_rvalid_o = r_rvalid;
  assign apu_rdata_o  = r_rdata;
  assign apu_rflags_o = r_rflags;
  assign busy_o       = w_busy;
  assign err_o        = r_err;

endmodule

// File: doc/cv32e40p_apu_arbiter.md
CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of APU requesters sharing one FP unit (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight operations per requester (1..15).
REQ-003 SHALL have derived localparam ID_W = max(1, $clog2(NUM_REQ)), the tag width.
REQ-004 SHALL have clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have apu_req_i  input  NUM_REQ  per-requester request.
REQ-007 SHALL have apu_gnt_o  output  NUM_REQ  per-requester grant.
REQ-008 SHALL have apu_operands_i  input  NUM_REQ x APU_NARGS_CPU x 32  per-requester operands.
REQ-009 SHALL have apu_op_i  input  NUM_REQ x APU_WOP_CPU  per-requester operation.
REQ-010 SHALL have apu_flags_i  input  NUM_REQ x APU_NDSFLAGS_CPU  per-requester flags.
REQ-011 SHALL have apu_rvalid_o  output  NUM_REQ  per-requester result valid.
REQ-012 SHALL have apu_rdata_o  output  NUM_REQ x 32  per-requester result.
REQ-013 SHALL have apu_rflags_o  output  NUM_REQ x APU_NUSFLAGS_CPU  per-requester status flags.
REQ-014 SHALL have fpu_req_o / fpu_gnt_i  output / input  1 / 1  request handshake to the FP unit (its in_valid / in_ready).
REQ-015 SHALL have fpu_operands_o, fpu_op_o, fpu_flags_o  output  same widths as one requester  muxed payload.
REQ-016 SHALL have fpu_tag_o  output  ID_W  index of the selected requester.
REQ-017 SHALL have fpu_rvalid_i, fpu_rdata_i (32), fpu_rflags_i (APU_NUSFLAGS_CPU), fpu_tag_i (ID_W)  input  FP unit response; the FP unit's out_ready is held at 1, so no response back-pressure exists.
REQ-018 SHALL have busy_o  output  1  high while any outstanding count is nonzero.
REQ-019 SHALL have err_o  output  1  sticky flag for a response with an invalid or unexpected tag.

Function
REQ-020 Eligibility: requester i is eligible when apu_req_i[i]=1 and outst[i] < MAX_OUTSTANDING.
REQ-021 Arbitration: combinational round-robin over eligible requesters, searching from rr_ptr upward with wrap-around; result is sel.
REQ-022 Lock: if fpu_req_o=1 and fpu_gnt_i=0, lock_q is set to 1 and lock_id_q to sel; while lock_q=1, sel=lock_id_q regardless of the other requesters.
REQ-023 Lock release: lock_q clears on the cycle fpu_gnt_i=1, or when apu_req_i[lock_id_q] drops.
REQ-024 fpu_req_o = (any requester eligible) or lock_q with apu_req_i[lock_id_q]; payload outputs and fpu_tag_o = sel.
REQ-025 apu_gnt_o[sel] = fpu_gnt_i and fpu_req_o; all other grant bits are 0; a grant is issued in the same cycle (zero added latency).
REQ-026 rr_ptr updates only on an accepted handshake, to (sel+1) mod NUM_REQ; otherwise it holds.
REQ-027 outst[i] increments on an accepted handshake with sel=i, and decrements on fpu_rvalid_i with fpu_tag_i=i.
REQ-028 If outst[i] both increments and decrements in the same cycle, it is unchanged.
REQ-029 Response routing is registered: apu_rvalid_o[fpu_tag_i], apu_rdata_o and apu_rflags_o are driven exactly one cycle after fpu_rvalid_i; all other rvalid bits are 0.
REQ-030 apu_rdata_o and apu_rflags_o of a requester hold their last value when its rvalid is 0.
REQ-031 If fpu_tag_i >= NUM_REQ, or outst[fpu_tag_i]=0, on fpu_rvalid_i: the response is dropped, the counter stays 0, and err_o sets; err_o clears only on reset.
REQ-032 A requester at MAX_OUTSTANDING is skipped until a response frees a slot; a locked requester at MAX is not revoked.

Reset
REQ-033 During reset: apu_gnt_o=0, apu_rvalid_o=0, apu_rdata_o=0, apu_rflags_o=0, fpu_req_o=0, busy_o=0, err_o=0, rr_ptr=0, lock_q=0, all outst=0.
REQ-034 Reset asserted mid-operation clears all state immediately; in-flight FP unit responses arriving after release count as unexpected per REQ-031.

Verification
REQ-035 Both requesters hold req, fpu_gnt_i=1 every cycle -> grants alternate 0,1,0,1; fpu_tag_o matches the granted index.
REQ-036 Req0 presented with fpu_gnt_i=0 for 3 cycles while req1 rises -> sel stays 0 and payload stays stable; grant goes to 0 on cycle 4, then to 1.
REQ-037 MAX_OUTSTANDING=4, req0 only, no responses -> 4 grants, then fpu_req_o=0; one tag-0 response -> a 5th grant follows.
REQ-038 fpu_rvalid_i with tag=1 and rdata=0x3F800000 -> apu_rvalid_o=2'b10 and apu_rdata_o[1]=0x3F800000 one cycle later.
REQ-039 Grant to requester 0 coinciding with a tag-0 response -> outst[0] unchanged, busy_o unchanged.
REQ-040 Response with tag=0 while outst[0]=0 -> no apu_rvalid_o, err_o=1 sticky until rst_ni=0.
